// File: rtl/register_ctrl_pkg.sv
// Shared types and default widths for the register bank load sequencer.
package register_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      CLEAR = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned DefDataWidth = 8;
   localparam int unsigned DefNumReq    = 4;
   localparam int unsigned DefNumRegs   = 8;
   localparam int unsigned DefAddrWidth = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at Ptr and wraps to 0.
module rr_arbiter #(
   parameter int unsigned NumReq = 4
) (
   input  logic [NumReq-1:0]         Req,
   input  logic [$clog2(NumReq)-1:0] Ptr,
   output logic [NumReq-1:0]         Grant,
   output logic [$clog2(NumReq)-1:0] GrantIdx,
   output logic                      Valid
);

   localparam int unsigned IdxW = $clog2(NumReq);

   int unsigned idx;

   // First requester found at or after Ptr, in wrapped order, wins.
   always_comb begin
      Grant    = '0;
      GrantIdx = '0;
      Valid    = 1'b0;
      idx      = 0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         idx = (32'(Ptr) + k) % NumReq;
         if (!Valid && Req[IdxW'(idx)]) begin
            Valid              = 1'b1;
            Grant[IdxW'(idx)]  = 1'b1;
            GrantIdx           = IdxW'(idx);
         end
      end
   end

endmodule

// File: rtl/register_load_arbiter.sv
// Sequencer sharing one register bank among several requesters: round-robin
// loads through active-low strobes, and bank-wide clears through RegClr_n.
module register_load_arbiter
   import register_ctrl_pkg::*;
#(
   parameter int unsigned DataWidth = DefDataWidth,
   parameter int unsigned NumReq    = DefNumReq,
   parameter int unsigned NumRegs   = DefNumRegs,
   parameter int unsigned AddrWidth = DefAddrWidth
) (
   input  logic                           Clk,
   input  logic                           Reset,
   input  logic [NumReq-1:0]              Req,
   input  logic [NumReq*AddrWidth-1:0]    ReqAddr,
   input  logic [NumReq*DataWidth-1:0]    ReqData,
   input  logic                           ClrReq,
   output logic [NumReq-1:0]              Ack,
   output logic                           AddrErr,
   output logic                           ClrAck,
   output logic [NumRegs-1:0]             RegLD,
   output logic [DataWidth-1:0]           RegDIn,
   output logic                           RegClr_n,
   output logic                           Busy
);

   localparam int unsigned PtrW = $clog2(NumReq);

   state_e                 state_q, state_d;
   logic [PtrW-1:0]        ptr_q, ptr_d;
   logic [PtrW-1:0]        win_q, win_d;
   logic [AddrWidth-1:0]   addr_q, addr_d;
   logic [DataWidth-1:0]   data_q, data_d;
   logic                   clr_q, clr_d;

   logic [NumReq-1:0]      gnt_oh;
   logic [PtrW-1:0]        gnt_idx;
   logic                   gnt_valid;

   logic [NumRegs-1:0]     ld_q, ld_d;
   logic [DataWidth-1:0]   din_q, din_d;
   logic                   clrn_q, clrn_d;
   logic [NumReq-1:0]      ack_q, ack_d;
   logic                   err_q, err_d;
   logic                   clrack_q, clrack_d;
   logic                   busy_q, busy_d;

   rr_arbiter #(
      .NumReq (NumReq)
   ) u_arb (
      .Req      (Req),
      .Ptr      (ptr_q),
      .Grant    (gnt_oh),
      .GrantIdx (gnt_idx),
      .Valid    (gnt_valid)
   );

   // State, grant latches and registered outputs; reset holds the bank clear low.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         win_q    <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         clr_q    <= 1'b0;
         ld_q     <= '1;
         din_q    <= '0;
         clrn_q   <= 1'b0;
         ack_q    <= '0;
         err_q    <= 1'b0;
         clrack_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         clr_q    <= clr_d;
         ld_q     <= ld_d;
         din_q    <= din_d;
         clrn_q   <= clrn_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
         clrack_q <= clrack_d;
         busy_q   <= busy_d;
      end
   end

   // Next state and grant capture; a clear outranks any load request in IDLE.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      win_d   = win_q;
      addr_d  = addr_q;
      data_d  = data_q;
      clr_d   = clr_q;
      unique case (state_q)
         IDLE: begin
            if (ClrReq) begin
               state_d = CLEAR;
               clr_d   = 1'b1;
            end else if (gnt_valid) begin
               state_d = LOAD;
               clr_d   = 1'b0;
               win_d   = gnt_idx;
               ptr_d   = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
               for (int unsigned k = 0; k < NumReq; k++) begin
                  if (gnt_oh[k]) begin
                     addr_d = ReqAddr[k*AddrWidth +: AddrWidth];
                     data_d = ReqData[k*DataWidth +: DataWidth];
                  end
               end
            end
         end
         LOAD:    state_d = DONE;
         CLEAR:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from next state so every output is a flop.
   always_comb begin
      ld_d = '1;
      for (int unsigned r = 0; r < NumRegs; r++) begin
         if (state_d == LOAD && 32'(addr_d) == r) begin
            ld_d[r] = 1'b0;
         end
      end
      din_d = data_d;
      clrn_d = (state_d != CLEAR);
      ack_d = '0;
      if (state_d == DONE && !clr_d) begin
         for (int unsigned k = 0; k < NumReq; k++) begin
            if (32'(win_d) == k) begin
               ack_d[k] = 1'b1;
            end
         end
      end
      err_d    = (state_d == DONE) && !clr_d && (32'(addr_d) >= NumRegs);
      clrack_d = (state_d == DONE) && clr_d;
      busy_d   = (state_d != IDLE);
   end

   assign RegLD    = ld_q;
   assign RegDIn   = din_q;
   assign RegClr_n = clrn_q;
   assign Ack      = ack_q;
   assign AddrErr  = err_q;
   assign ClrAck   = clrack_q;
   assign Busy     = busy_q;

endmodule

// File: tb/tb_register_load_arbiter.sv
// Self-checking bench for register_load_arbiter: directed scenarios plus random
// traffic, checked cycle by cycle against a transaction-level timeline model.
module tb_register_load_arbiter;

   localparam int unsigned DW = 8;
   localparam int unsigned NR = 4;
   localparam int unsigned NG = 8;
   localparam int unsigned AW = 4;

   logic                Clk;
   logic                Reset;
   logic [NR-1:0]       Req;
   logic [NR*AW-1:0]    ReqAddr;
   logic [NR*DW-1:0]    ReqData;
   logic                ClrReq;
   logic [NR-1:0]       Ack;
   logic                AddrErr;
   logic                ClrAck;
   logic [NG-1:0]       RegLD;
   logic [DW-1:0]       RegDIn;
   logic                RegClr_n;
   logic                Busy;

   logic [AW-1:0]       req_addr [NR];
   logic [DW-1:0]       req_data [NR];

   register_load_arbiter #(
      .DataWidth (DW),
      .NumReq    (NR),
      .NumRegs   (NG),
      .AddrWidth (AW)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .Req      (Req),
      .ReqAddr  (ReqAddr),
      .ReqData  (ReqData),
      .ClrReq   (ClrReq),
      .Ack      (Ack),
      .AddrErr  (AddrErr),
      .ClrAck   (ClrAck),
      .RegLD    (RegLD),
      .RegDIn   (RegDIn),
      .RegClr_n (RegClr_n),
      .Busy     (Busy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   always_comb begin
      for (int unsigned i = 0; i < NR; i++) begin
         ReqAddr[i*AW +: AW] = req_addr[i];
         ReqData[i*DW +: DW] = req_data[i];
      end
   end

   // The register bank the sequencer drives: synchronous active-low clear, active-low load.
   logic [DW-1:0] bank [NG];
   always @(posedge Clk) begin
      for (int r = 0; r < NG; r++) begin
         if (!RegClr_n)   bank[r] <= '0;
         else if (!RegLD[r]) bank[r] <= RegDIn;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   // Model: one operation record aged in cycles since its grant edge.
   int            op_kind = 0;     // 0 none, 1 load, 2 clear
   int            op_age  = 0;     // 0 = LOAD/CLEAR cycle, 1 = completion cycle
   int            op_w    = 0;
   logic [AW-1:0] op_addr = '0;
   logic [DW-1:0] op_data = '0;
   int            m_ptr   = 0;
   logic [DW-1:0] ref_bank [NG];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: compare outputs mid-cycle, then advance the model across the edge.
   task automatic step();
      bit            act, done;
      logic [NG-1:0] e_ld;
      logic [NR-1:0] e_ack;
      int            new_kind, new_w;
      logic [AW-1:0] new_addr;
      logic [DW-1:0] new_data;
      @(negedge Clk);
      act  = (op_kind != 0) && (op_age == 0);
      done = (op_kind != 0) && (op_age == 1);
      e_ld = '1;
      for (int r = 0; r < NG; r++)
         if (act && op_kind == 1 && r == int'(op_addr)) e_ld[r] = 1'b0;
      e_ack = '0;
      for (int k = 0; k < NR; k++)
         if (done && op_kind == 1 && k == op_w) e_ack[k] = 1'b1;
      check_eq("Busy", 32'(Busy), 32'(act || done));
      check_eq("RegLD", 32'(RegLD), 32'(e_ld));
      check_eq("RegClr_n", 32'(RegClr_n), 32'(!(act && op_kind == 2)));
      check_eq("Ack", 32'(Ack), 32'(e_ack));
      check_eq("AddrErr", 32'(AddrErr), 32'(done && op_kind == 1 && int'(op_addr) >= NG));
      check_eq("ClrAck", 32'(ClrAck), 32'(done && op_kind == 2));
      if (act && op_kind == 1) check_eq("RegDIn", 32'(RegDIn), 32'(op_data));
      new_kind = 0;
      new_w    = 0;
      new_addr = '0;
      new_data = '0;
      if (!(act || done)) begin
         if (ClrReq) new_kind = 2;
         else begin
            for (int k = 0; k < NR; k++) begin
               if (new_kind == 0 && Req[(m_ptr + k) % NR]) begin
                  new_kind = 1;
                  new_w    = (m_ptr + k) % NR;
               end
            end
            if (new_kind == 1) begin
               new_addr = req_addr[new_w];
               new_data = req_data[new_w];
            end
         end
      end
      @(posedge Clk);
      #1;
      if (act && op_kind == 1 && int'(op_addr) < NG) ref_bank[op_addr] = op_data;
      if (act && op_kind == 2) foreach (ref_bank[r]) ref_bank[r] = '0;
      op_age++;
      if (new_kind != 0) begin
         op_kind = new_kind;
         op_age  = 0;
         if (new_kind == 1) begin
            op_w    = new_w;
            op_addr = new_addr;
            op_data = new_data;
            m_ptr   = (new_w + 1) % NR;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic do_reset();
      Reset  = 1'b1;
      Req    = '0;
      ClrReq = 1'b0;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      check_eq("rst_RegLD", 32'(RegLD), 32'(8'hFF));
      check_eq("rst_RegClr_n", 32'(RegClr_n), 32'd0);
      check_eq("rst_RegDIn", 32'(RegDIn), 32'd0);
      check_eq("rst_Busy", 32'(Busy), 32'd0);
      check_eq("rst_Ack", 32'(Ack), 32'd0);
      check_eq("rst_AddrErr", 32'(AddrErr), 32'd0);
      check_eq("rst_ClrAck", 32'(ClrAck), 32'd0);
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      op_kind = 0;
      op_age  = 0;
      m_ptr   = 0;
      foreach (ref_bank[r]) ref_bank[r] = '0;
   endtask

   task automatic check_bank(input string tag);
      for (int r = 0; r < NG; r++) check_eq(tag, 32'(bank[r]), 32'(ref_bank[r]));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      Reset  = 1'b1;
      Req    = '0;
      ClrReq = 1'b0;
      for (int i = 0; i < NR; i++) begin
         req_addr[i] = AW'(i);
         req_data[i] = '0;
      end
      do_reset();
      check_bank("bank_after_reset");

      // Single load: requester 1 writes A5 into register 3.
      req_addr[1] = 4'd3;
      req_data[1] = 8'hA5;
      Req = 4'b0010;
      run(3);
      Req = '0;
      run(1);
      check_eq("bank3_A5", 32'(bank[3]), 32'h0000_00A5);

      // All requesters held: rotation 0,1,2,3,0 at one op per 3 cycles.
      for (int i = 0; i < NR; i++) begin
         req_addr[i] = AW'(i + 4);
         req_data[i] = DW'($urandom);
      end
      Req = 4'b1111;
      run(15);
      Req = '0;
      run(1);
      check_bank("bank_rr");

      // Clear and request together: clear first, then requester 2.
      req_addr[2] = 4'd5;
      req_data[2] = 8'h3C;
      ClrReq = 1'b1;
      Req    = 4'b0100;
      run(3);
      ClrReq = 1'b0;
      run(3);
      Req = '0;
      run(1);
      check_eq("bank5_3C", 32'(bank[5]), 32'h0000_003C);
      check_eq("bank3_cleared", 32'(bank[3]), 32'd0);
      check_bank("bank_clr");

      // Out-of-range index: no strobe, Ack with AddrErr.
      req_addr[0] = 4'd9;
      Req = 4'b0001;
      run(3);
      Req = '0;
      run(1);

      // Reset during LOAD aborts without Ack; pointer restarts at 0.
      Req = 4'b0100;
      run(1);
      Reset = 1'b1;
      #1;
      check_eq("async_RegLD", 32'(RegLD), 32'(8'hFF));
      check_eq("async_Busy", 32'(Busy), 32'd0);
      check_eq("async_RegClr_n", 32'(RegClr_n), 32'd0);
      do_reset();
      for (int i = 0; i < NR; i++) req_addr[i] = AW'(i);
      Req = 4'b1111;
      run(3);
      Req = '0;
      run(1);

      // Requester 3 drops its request right after the grant.
      Req = 4'b1000;
      run(1);
      Req = '0;
      run(3);
      check_bank("bank_directed");

      // Random traffic.
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (Req[i]) Req[i] = ($urandom_range(0, 9) != 0);
            else        Req[i] = ($urandom_range(0, 3) == 0);
            req_addr[i] = AW'($urandom_range(0, 15));
            req_data[i] = DW'($urandom);
         end
         ClrReq = ($urandom_range(0, 19) == 0);
         step();
      end
      Req    = '0;
      ClrReq = 1'b0;
      run(3);
      check_bank("bank_random");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/register_load_arbiter.md
# register_load_arbiter

Sequencer that shares one bank of `Register` instances among several requesters. It arbitrates load requests round-robin, drives the bank's active-low per-register load strobes and the shared data bus, and acknowledges each completed load. It also serves a bank-wide clear request through the registers' shared active-low synchronous reset. It sits between the requesting datapath units and the register bank.

## Interface
- `DataWidth`, 8, width of each register and of each request data field
- `NumReq`, 4, number of requesters (2..8)
- `NumRegs`, 8, number of registers in the bank (1..16)
- `AddrWidth`, 4, register index width; must satisfy 2^AddrWidth >= NumRegs
- `Clk`  in  1  clock; all state changes on the rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Req`  in  NumReq  level request per requester; held high until its `Ack`
- `ReqAddr`  in  NumReq*AddrWidth  target register index; requester i occupies slice i
- `ReqData`  in  NumReq*DataWidth  load value; requester i occupies slice i
- `ClrReq`  in  1  level request to clear the whole bank; held high until `ClrAck`
- `Ack`  out  NumReq  one-cycle completion pulse for the granted requester
- `AddrErr`  out  1  one-cycle pulse coincident with `Ack` when the index is >= NumRegs
- `ClrAck`  out  1  one-cycle completion pulse for a clear
- `RegLD`  out  NumRegs  active-low load strobe per register, at most one low per cycle
- `RegDIn`  out  DataWidth  shared data bus to all register `DIn`
- `RegClr_n`  out  1  active-low clear to all register reset inputs
- `Busy`  out  1  high in every state except IDLE

## Operation
- States: IDLE, LOAD, CLEAR, DONE.
- IDLE with `ClrReq` high:
  - go to CLEAR; clear has priority over all `Req`.
- IDLE with `ClrReq` low and any `Req` high:
  - select the winner round-robin, starting the search at pointer `Ptr` and wrapping from NumReq-1 to 0.
  - latch the winner's index, address and data.
  - set `Ptr` to winner+1 modulo NumReq.
  - go to LOAD.
- LOAD (one cycle):
  - `RegDIn` carries the latched data.
  - `RegLD[addr]` is 0; all other bits are 1.
  - If addr >= NumRegs, all `RegLD` bits stay 1.
  - go to DONE.
- CLEAR (one cycle): `RegClr_n` is 0; go to DONE.
- DONE (one cycle):
  - pulse `Ack[winner]`, or `ClrAck` if the operation was a clear.
  - pulse `AddrErr` if the load index was out of range.
  - return to IDLE.
- A requester drops `Req` in the cycle after its `Ack`, or keeps it high to queue another load.
- Dropping `Req` before `Ack`:
  - a grant already latched still completes and is acknowledged.
  - a request not yet granted is simply never served.
- `ReqAddr` and `ReqData` are sampled only in the IDLE grant cycle; later changes are ignored.
- A `ClrReq` that arrives while a load is in progress waits for IDLE.
- A clear resets `RegClr_n`-driven registers only; `Ptr` is unaffected.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Load latency: `Req` high at edge N (IDLE) -> `RegLD` low during cycle N+1 -> register updates at edge N+2 -> `Ack` high during cycle N+2.
- Throughput: one operation per 3 cycles under continuous requests.
- Reset values: `RegLD` all ones, `RegDIn` 0, `RegClr_n` 0, `Ack` 0, `AddrErr` 0, `ClrAck` 0, `Busy` 0, `Ptr` 0, state IDLE.
  - `RegClr_n` is held low during `Reset`, so the bank clears synchronously on any clock edge within reset.
  - `RegClr_n` rises on the first edge after `Reset` deasserts.
- `Reset` asserted mid-operation:
  - aborts immediately, and no `Ack` is issued for the aborted load.
  - requesters must re-present the request.
- Simultaneous `ClrReq` and `Req` in IDLE: the clear is served first, and the `Req` is granted in the IDLE cycle after `ClrAck`.

## Structure
- Shared package `register_ctrl_pkg`:
  - state encoding constants IDLE=2'd0, LOAD=2'd1, CLEAR=2'd2, DONE=2'd3.
  - default widths for `DataWidth`, `NumRegs` and `AddrWidth`.
- Sub-module `rr_arbiter` (parameter `NumReq`):
  - inputs: request vector and pointer.
  - outputs: one-hot grant, grant index, `Valid`.
  - purely combinational; `Ptr` stays in the parent.
- The parent holds the FSM, the latches and the output registers.

## Test plan
- Reset, then `Req[1]=1`, `ReqAddr[1]=3`, `ReqData[1]=8'hA5` -> `RegLD`=8'b1111_0111 for one cycle, register 3 reads A5, `Ack[1]` pulses at grant+2.
- `Req`=4'b1111 held, all addresses distinct -> grants in order 0,1,2,3,0, one `Ack` every 3 cycles, never two `RegLD` bits low at once.
- `ClrReq` and `Req[2]` raised in the same cycle -> `RegClr_n` low one cycle, `ClrAck` pulses, then requester 2 is loaded, and all other registers read 0.
- `NumRegs`=6, `ReqAddr[0]`=7 -> `RegLD` stays all ones, `Ack[0]` and `AddrErr` pulse together.
- `Reset` asserted during LOAD -> outputs return to reset values asynchronously, no `Ack`, and after release the first grant starts from requester 0.
- `Req[3]` dropped one cycle after its grant -> load still completes and `Ack[3]` still pulses.
